// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush and data-memory wait freeze.
// Define HAZARD_STALL_PERF_EN to add saturating lu/mem/flush event counters as extra outputs.
module hazard_stall_controller #(
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       pipe_freeze,
  output logic       mem_timeout,
  output logic [1:0] state_o
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] mem_stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              lu_hazard;
  logic              mem_stall;

  assign lu_hazard = ex_memread & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign mem_stall = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q == LAST_WAIT) begin
            state_d       = ST_ERR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Either the access completed or the requester abandoned it.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Reset forces a safe NOP-injecting pattern; otherwise strict priority ERR > stall > branch > load-use.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state_q == ST_ERR) || mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

`ifdef HAZARD_STALL_PERF_EN
  logic        ev_lu, ev_mem, ev_flush;
  logic [15:0] lu_stall_cnt_q, lu_stall_cnt_d;
  logic [15:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    ev_mem          = (state_q != ST_ERR) & mem_stall;
    ev_flush        = (state_q != ST_ERR) & ~mem_stall & ex_branch_taken;
    ev_lu           = (state_q != ST_ERR) & ~mem_stall & ~ex_branch_taken & lu_hazard;
    lu_stall_cnt_d  = sat_inc(lu_stall_cnt_q, ev_lu);
    mem_stall_cnt_d = sat_inc(mem_stall_cnt_q, ev_mem);
    flush_cnt_d     = sat_inc(flush_cnt_q, ev_flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt_q  <= '0;
      mem_stall_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      lu_stall_cnt_q  <= lu_stall_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign lu_stall_cnt  = lu_stall_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios plus randomized segments against a
// reference model tracking the length of the current memory-stall streak and a sticky error.
module tb_hazard_stall_controller;

  localparam int MW = 4;
  localparam int WW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_memread = 1'b0;
  logic       ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [1:0] state_o;
`ifdef HAZARD_STALL_PERF_EN
  logic [15:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int streak = 0;
  bit err = 1'b0;
  int m_lu = 0, m_ms = 0, m_fl = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MAX_WAIT(MW), .WAIT_W(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .state_o(state_o)
`ifdef HAZARD_STALL_PERF_EN
    , .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout, state_o};
  endfunction

  function automatic bit lu_now();
    return ex_memread && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit ms_now();
    return mem_req && !mem_ready;
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout, state_o}
  function automatic logic [7:0] model_outs();
    logic [4:0] ctl;
    logic [1:0] st;
    if (!rst_n)                ctl = 5'b00110;
    else if (err || ms_now())  ctl = 5'b00001;
    else if (ex_branch_taken)  ctl = 5'b11110;
    else if (lu_now())         ctl = 5'b00010;
    else                       ctl = 5'b11000;
    st = err ? 2'd2 : (streak > 0 ? 2'd1 : 2'd0);
    return {ctl, err, st};
  endfunction

  task automatic model_reset();
    streak = 0; err = 1'b0; m_lu = 0; m_ms = 0; m_fl = 0;
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
    end else if (!err) begin
      if (ms_now())             begin if (m_ms < 65535) m_ms++; end
      else if (ex_branch_taken) begin if (m_fl < 65535) m_fl++; end
      else if (lu_now())        begin if (m_lu < 65535) m_lu++; end
      if (ms_now()) begin
        streak++;
        if (streak == MW) err = 1'b1;
      end else begin
        streak = 0;
      end
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cyc(input string tag);
    #1;
    check_eq(tag, dut_outs(), model_outs());
`ifdef HAZARD_STALL_PERF_EN
    check_eq({tag, "_lucnt"}, lu_stall_cnt, m_lu);
    check_eq({tag, "_mscnt"}, mem_stall_cnt, m_ms);
    check_eq({tag, "_flcnt"}, flush_cnt, m_fl);
`endif
    model_advance();
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_outs", dut_outs(), 8'b0011_0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs(input int preq, input int prdy);
    ex_rd           = 5'($urandom_range(0, 3));
    id_rs1          = 5'($urandom_range(0, 3));
    id_rs2          = 5'($urandom_range(0, 3));
    id_uses_rs1     = 1'($urandom_range(0, 1));
    id_uses_rs2     = 1'($urandom_range(0, 1));
    ex_memread      = 1'($urandom_range(0, 1));
    ex_branch_taken = ($urandom_range(0, 4) == 0);
    mem_req         = ($urandom_range(0, 99) < preq);
    mem_ready       = ($urandom_range(0, 99) < prdy);
  endtask

  initial begin
    set_idle();
    @(negedge clk);
    do_reset();

    // Load-use on rs1, then load gone
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    check_eq("lu_pc", pc_write, 1'b0);
    check_eq("lu_bubble", idex_bubble, 1'b1);
    cyc("lu");
    ex_memread = 1'b0;
    #1;
    check_eq("lu_release_pc", pc_write, 1'b1);
    cyc("lu_release");

    // Load to x0 never stalls
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    check_eq("x0_pc", pc_write, 1'b1);
    check_eq("x0_bubble", idex_bubble, 1'b0);
    cyc("x0");

    // Branch beats load-use
    ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
    #1;
    check_eq("br_lu", {ifid_flush, idex_bubble, pc_write}, 3'b111);
    cyc("br_lu");
    set_idle();

    // Single-cycle access stays in RUN
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    check_eq("mem1_freeze", pipe_freeze, 1'b0);
    cyc("mem1");
    set_idle();
    #1;
    check_eq("mem1_state", state_o, 2'b00);
    cyc("mem1_after");

    // Three wait cycles then ready
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("wait_freeze", {pipe_freeze, pc_write}, 2'b10);
      check_eq("wait_state", state_o, (i == 0) ? 2'b00 : 2'b01);
      cyc("wait");
    end
    mem_ready = 1'b1;
    #1;
    check_eq("ready_freeze", pipe_freeze, 1'b0);
    check_eq("ready_state", state_o, 2'b01);
    cyc("ready");
    set_idle();
    #1;
    check_eq("after_ready_state", state_o, 2'b00);
    cyc("after_ready");

    // Requester drops mid-wait
    mem_req = 1'b1;
    cyc("drop_w0");
    cyc("drop_w1");
    mem_req = 1'b0;
    cyc("drop");
    #1;
    check_eq("drop_state", state_o, 2'b00);
    cyc("drop_after");

    // Timeout after MW wait cycles, then asynchronous reset out of ERR
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (MW) cyc("to_wait");
    #1;
    check_eq("to_state", state_o, 2'b10);
    check_eq("to_flag", mem_timeout, 1'b1);
    set_idle();
    cyc("err_hold");
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_state", state_o, 2'b00);
    check_eq("async_flag", mem_timeout, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef HAZARD_STALL_PERF_EN
    // Two load-use stalls plus three memory-wait cycles
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      cyc("perf_lu");
      set_idle();
      cyc("perf_gap");
    end
    mem_req = 1'b1;
    repeat (3) cyc("perf_wait");
    mem_ready = 1'b1;
    cyc("perf_ready");
    set_idle();
    #1;
    check_eq("perf_lu_cnt", lu_stall_cnt, 16'd2);
    check_eq("perf_ms_cnt", mem_stall_cnt, 16'd3);
    check_eq("perf_fl_cnt", flush_cnt, 16'd0);
`endif

    // Randomized segments, each starting from reset with its own stall density
    for (int s = 0; s < 12; s++) begin
      int preq, prdy;
      preq = $urandom_range(20, 100);
      prdy = $urandom_range(0, 80);
      do_reset();
      for (int c = 0; c < 60; c++) begin
        rand_inputs(preq, prdy);
        cyc("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
